two_power_mod: RTL and testbench
================================

TWO_POWER_MOD -- requirements
Module: two_power_mod

Interface
REQ-001 The module SHALL have parameter MOD_WIDTH, default 256, giving the modulus and result width in bits.
REQ-002 The module SHALL have parameter INT_WIDTH, default 32, giving the exponent width in bits.
REQ-003 The module SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-004 The module SHALL have port rst, input, 1 bit: reset, asynchronous and active-high.
REQ-005 The module SHALL have port i_valid, input, 1 bit: input request valid.
REQ-006 The module SHALL have port i_ready, output, 1 bit: block can accept a request.
REQ-007 The module SHALL have port i_in, input, INT_WIDTH+MOD_WIDTH bits: packed RSATwoPowerModIn {power, modulus}, with power in the MSBs.
REQ-008 The module SHALL have port o_valid, output, 1 bit: result valid.
REQ-009 The module SHALL have port o_ready, input, 1 bit: downstream accepts the result.
REQ-010 The module SHALL have port o_out, output, MOD_WIDTH bits: RSATwoPowerModOut, equal to 2^power mod modulus; it is the R^2 mod N pre-factor for the Montgomery stage.

Function
REQ-011 The module SHALL implement FSM states IDLE, CALC and DONE.
REQ-012 i_ready SHALL be 1 only in IDLE; o_valid SHALL be 1 only in DONE; only one request is in flight and there is no overlap.
REQ-013 An input handshake (i_valid && i_ready at an edge) SHALL latch modulus into an internal register.
REQ-014 The same handshake SHALL load accumulator r (MOD_WIDTH+1 bits) with 1 if modulus > 1, otherwise 0.
REQ-015 The same handshake SHALL load counter cnt (INT_WIDTH bits) with power.
REQ-016 On that handshake the next state SHALL be DONE if power == 0, otherwise CALC.
REQ-017 Each CALC edge SHALL set t = r << 1, then r <= (t >= modulus) ? t - modulus : t, and cnt <= cnt - 1; one modular doubling per cycle.
REQ-018 The module SHALL leave CALC for DONE on the edge where cnt == 1.
REQ-019 Latency SHALL be exactly power+1 rising edges from the accept edge (counted as edge 1) to o_valid high; power=0 gives 1 edge.
REQ-020 In DONE, o_out SHALL equal r[MOD_WIDTH-1:0] and o_valid SHALL be 1.
REQ-021 In DONE, o_out SHALL hold stable while o_ready is 0, for any number of cycles.
REQ-022 The module SHALL go from DONE to IDLE on the edge where o_valid && o_ready; i_ready SHALL rise in the following cycle, with no same-cycle turnaround.
REQ-023 i_in SHALL be ignored outside the accept edge; changes to it during CALC or DONE SHALL not affect the result.
REQ-024 modulus == 0 or modulus == 1 SHALL yield o_out = 0 after the normal latency.
REQ-025 The result SHALL be correct for any modulus >= 2, odd or even, including 2^MOD_WIDTH-1, with no overflow, using the MOD_WIDTH+1-bit intermediate.
REQ-026 Outside DONE, o_out SHALL be 0.

Reset
REQ-027 While rst is 1, the module SHALL hold state = IDLE, r = 0, cnt = 0, modulus register = 0, o_valid = 0, o_out = 0 and i_ready = 1, independent of clk.
REQ-028 rst asserted mid-CALC or mid-DONE SHALL abort the operation with no result emitted; the first accept after rst falls SHALL start a fresh computation.

Configuration
REQ-029 With macro TWO_POWER_MOD_ASSERT_EN defined, the module SHALL include simulation checks: i_in stable while i_valid && !i_ready; i_valid does not drop before handshake; o_out stable while o_valid && !o_ready; no unknowns on o_valid or i_ready after reset.
REQ-030 Each failed check SHALL raise $error with the check name.
REQ-031 Without TWO_POWER_MOD_ASSERT_EN, no check logic SHALL be compiled, and port behaviour and timing SHALL be identical.

Verification
REQ-032 power=0, modulus=7 -> o_valid 1 edge after accept, o_out=1.
REQ-033 power=10, modulus=1000 -> o_valid exactly 11 edges after accept, o_out=24.
REQ-034 power=512, modulus=2^256-189 -> o_valid after 513 edges, o_out=35721 (189^2).
REQ-035 power=5, modulus=1 -> o_out=0; then power=3, modulus=0 -> o_out=0; latency 6 and 4 edges.
REQ-036 power=10, modulus=1000 with o_ready held 0 for 5 cycles after o_valid -> o_out stays 24 and i_ready stays 0; o_ready=1 -> IDLE next edge; i_in changed mid-CALC -> result unaffected.
REQ-037 rst pulsed at CALC edge 4 of power=100 -> outputs return to reset values immediately; next request power=10, modulus=1000 -> o_out=24.

Source files
------------

// File: rtl/two_power_mod.sv
// two_power_mod: iterative 2^power mod modulus (R^2 mod N pre-factor); optional checks via TWO_POWER_MOD_ASSERT_EN
module two_power_mod #(
    parameter int MOD_WIDTH = 256,
    parameter int INT_WIDTH = 32
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           i_valid,
    output logic                           i_ready,
    input  logic [INT_WIDTH+MOD_WIDTH-1:0] i_in,
    output logic                           o_valid,
    input  logic                           o_ready,
    output logic [MOD_WIDTH-1:0]           o_out
);
    typedef enum logic [1:0] {IDLE, CALC, DONE} stateType;
    stateType state;
    logic [MOD_WIDTH:0] r, dbl, red;
    logic [MOD_WIDTH-1:0] modReg, inMod;
    logic [INT_WIDTH-1:0] cnt, inPow;
    assign inPow = i_in[INT_WIDTH+MOD_WIDTH-1 -: INT_WIDTH];
    assign inMod = i_in[MOD_WIDTH-1:0];
    assign dbl = r << 1;
    assign red = (dbl >= {1'b0, modReg}) ? dbl - {1'b0, modReg} : dbl;
    assign i_ready = state == IDLE;
    assign o_valid = state == DONE;
    assign o_out = o_valid ? r[MOD_WIDTH-1:0] : '0;
    // accept a request, do one modular doubling per CALC cycle, hold the result until taken
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            r <= '0;
            cnt <= '0;
            modReg <= '0;
        end else begin
            case (state)
                IDLE: if (i_valid) begin
                    modReg <= inMod;
                    r <= (MOD_WIDTH+1)'(inMod > MOD_WIDTH'(1));
                    cnt <= inPow;
                    state <= (inPow == '0) ? DONE : CALC;
                end
                CALC: begin
                    r <= red;
                    cnt <= cnt - 1'b1;
                    if (cnt == INT_WIDTH'(1)) state <= DONE;
                end
                DONE: if (o_ready) state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end
`ifdef TWO_POWER_MOD_ASSERT_EN
    logic pIValid, pIReady, pOValid, pOReady;
    logic [INT_WIDTH+MOD_WIDTH-1:0] pIn;
    logic [MOD_WIDTH-1:0] pOut;
    // handshake protocol checks against the previous cycle's view of the ports
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            {pIValid, pIReady, pOValid, pOReady} <= '0;
            pIn <= '0;
            pOut <= '0;
        end else begin
            if (pIValid && !pIReady && i_in != pIn) $error("i_in_stable");
            if (pIValid && !pIReady && !i_valid) $error("i_valid_hold");
            if (pOValid && !pOReady && o_out != pOut) $error("o_out_stable");
            if ($isunknown({o_valid, i_ready})) $error("no_unknown");
            {pIValid, pIReady, pOValid, pOReady} <= {i_valid, i_ready, o_valid, o_ready};
            pIn <= i_in;
            pOut <= o_out;
        end
    end
`endif
endmodule

// File: tb/tb_two_power_mod.sv
// tb_two_power_mod: directed checks of two_power_mod latency, results, back-pressure and reset abort
module tb_two_power_mod;
    localparam int MW = 256;
    localparam int IW = 32;
    logic clk = 0, rst = 1, i_valid = 0, o_ready = 0;
    logic i_ready, o_valid;
    logic [IW+MW-1:0] i_in = '0;
    logic [MW-1:0] o_out;
    logic [MW-1:0] bigMod, allOnes, pow44, half;
    int errCnt = 0, chkCnt = 0;

    two_power_mod #(.MOD_WIDTH(MW), .INT_WIDTH(IW)) dut (
        .clk(clk), .rst(rst), .i_valid(i_valid), .i_ready(i_ready), .i_in(i_in),
        .o_valid(o_valid), .o_ready(o_ready), .o_out(o_out)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [MW-1:0] act, input logic [MW-1:0] want);
        chkCnt++;
        if (act !== want) begin
            errCnt++;
            $display("FAIL %s: got %0h want %0h", tag, act, want);
        end
    endtask

    task automatic run(input logic [IW-1:0] pow, input logic [MW-1:0] md, input int expLat,
                       input logic [MW-1:0] expOut, input int hold);
        int lat;
        @(negedge clk);
        check("idle_ready", i_ready, 1);
        check("idle_out", o_out, 0);
        i_in = {pow, md};
        i_valid = 1;
        @(posedge clk);
        #1;
        i_valid = 0;
        i_in = {9{$urandom}};
        lat = 1;
        if (pow != 0) begin
            check("busy_ready", i_ready, 0);
            check("busy_out", o_out, 0);
        end
        while (!o_valid && lat < 1000) begin
            @(posedge clk);
            #1;
            i_in = {9{$urandom}};
            lat++;
        end
        check("latency", lat, expLat);
        check("result", o_out, expOut);
        check("done_ready", i_ready, 0);
        repeat (hold) begin
            @(posedge clk);
            #1;
            check("hold_out", o_out, expOut);
            check("hold_valid", o_valid, 1);
            check("hold_ready", i_ready, 0);
        end
        o_ready = 1;
        @(posedge clk);
        #1;
        o_ready = 0;
        check("ret_ready", i_ready, 1);
        check("ret_valid", o_valid, 0);
        check("ret_out", o_out, 0);
    endtask

    initial begin
        bigMod = {MW{1'b1}} - MW'(188);
        allOnes = {MW{1'b1}};
        pow44 = MW'(1) << 44;
        half = MW'(1) << 255;
        #1;
        check("rst_ready", i_ready, 1);
        check("rst_valid", o_valid, 0);
        check("rst_out", o_out, 0);
        @(negedge clk);
        @(negedge clk);
        rst = 0;
        run(0, 7, 1, 1, 0);
        run(10, 1000, 11, 24, 0);
        run(512, bigMod, 513, 35721, 0);
        run(5, 1, 6, 0, 0);
        run(3, 0, 4, 0, 0);
        run(10, 1000, 11, 24, 5);
        run(3, 1000, 4, 8, 0);
        run(300, allOnes, 301, pow44, 0);
        run(256, half, 257, 0, 0);
        run(1, 2, 2, 0, 0);
        run(1, 3, 2, 2, 0);
        @(negedge clk);
        i_in = {32'd100, 256'd1000};
        i_valid = 1;
        @(posedge clk);
        #1;
        i_valid = 0;
        repeat (3) @(posedge clk);
        #1;
        rst = 1;
        #1;
        check("abort_ready", i_ready, 1);
        check("abort_valid", o_valid, 0);
        check("abort_out", o_out, 0);
        @(negedge clk);
        rst = 0;
        run(10, 1000, 11, 24, 0);
        $display("Result: errors=%0d of %0d checks", errCnt, chkCnt);
        $finish;
    end
endmodule
